fifo_asym_window: RTL and testbench
===================================

Name: fifo_asym_window

Overview:
- Parametrised asymmetric FIFO: one WIDTH-bit word written per cycle; a window of RD_WORDS consecutive words presented per cycle.
- Consumer pops a variable number of words (0..RD_WORDS), which supports sliding-window reuse in the conv datapath (e.g. stride-1 pops 1, non-overlapping pops RD_WORDS).
- Adds a drain mode to flush a partial tail window at end of a row/tile.
- Used as input/activation buffer between external memory stream and the PE array.

Parameters:
- WIDTH, 16, bits per stored word.
- DEPTH, 128, words of storage; power of two, must be >= 2*RD_WORDS.
- RD_WORDS, 3, words presented per read window.
- USE_AS_EXTERNAL_FIFO, 1, selects energy/area cost model for simulation-only accounting (1 = external cost, 0 = on-chip 0.1x energy).

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n_in  in  1  synchronous active-low reset.
- din  in  WIDTH  write data.
- input_valid  in  1  write request.
- input_ready  out  1  space available (count < DEPTH).
- qout  out  RD_WORDS*WIDTH  read window; lane i (bits i*WIDTH +: WIDTH) = i-th oldest word.
- valid_words  out  $clog2(RD_WORDS+1)  number of valid lanes in qout.
- output_valid  out  1  window available.
- output_ready  in  1  pop request.
- pop_count  in  $clog2(RD_WORDS+1)  words to consume on a pop; 0 = peek.
- drain  in  1  allow partial windows.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: wr_ptr, rd_ptr, each $clog2(DEPTH)+1 bits, wrapping mod 2*DEPTH; storage indexed by low $clog2(DEPTH) bits. Storage array is not reset.
- count = wr_ptr - rd_ptr (modular); full when count == DEPTH, empty when count == 0.
- Reset: on a clk edge with arst_n_in low, wr_ptr = rd_ptr = 0. While arst_n_in is low, input_ready = 0 and output_valid = 0. After release: count = 0, valid_words = 0, input_ready = 1, output_valid = 0.
- Reset mid-operation discards all contents; no write or pop takes effect on the reset edge.
- Write: push = input_valid & input_ready. Word is stored at wr_ptr and wr_ptr += 1. The word is visible in qout/count from the next cycle; no same-cycle bypass.
- input_ready depends only on registered count: no combinational path from output_ready/pop_count. When full, a write is refused even if a pop occurs in the same cycle.
- valid_words = min(count, RD_WORDS).
- output_valid = (count >= RD_WORDS) | (drain & count != 0).
- qout is combinational from storage:
  - lane i = data[rd_ptr+i] for i < valid_words, else 0.
  - When output_valid = 0, qout = 0 (never X).
- Pop: pop = output_valid & output_ready. rd_ptr += min(pop_count, valid_words), so pop_count above valid_words is clamped. pop_count = 0 with pop is a legal peek with no pointer change.
- Simultaneous push and pop: both applied; count_next = count + push - popped.
- Wrap-around: lanes index (rd_ptr+i) mod DEPTH, so windows straddling the storage end are contiguous.
- Simulation-only accounting:
  - Per pop: energy += valid_words*WIDTH*k.
  - Per push: energy += WIDTH*k.
  - k = 1 if USE_AS_EXTERNAL_FIFO, else 0.1.
  - Area is added once at time 0 when not external.
  - Excluded under TARGET_SYNTHESIS.

Test Plan:
- Reset then push 1,2,3 on consecutive cycles (no pops) -> output_valid rises the cycle after the 3rd push; qout lanes = {3,2,1}; count = 3; valid_words = 3.
- Push 1..5, then pop with pop_count = 1 repeatedly -> windows {3,2,1}, {4,3,2}, {5,4,3}; after the third pop count = 2 and output_valid = 0.
- Push 1..2, drain = 1 -> output_valid = 1, valid_words = 2, lane2 = 0. Pop with pop_count = 3 -> clamped to 2, count = 0, output_valid = 0.
- Fill DEPTH = 128 words -> input_ready = 0 at count = 128. A push and pop(3) in the same cycle: write refused, count = 125. Next cycle input_ready = 1.
- Stream 300 words with continuous push and pop_count = 3 -> data order preserved across ptr wrap (window straddling addresses 127/0 correct); no X on qout.
- Assert arst_n_in low for 1 cycle with count = 50 mid-stream -> the following cycle count = 0, output_valid = 0, input_ready = 1; the old data never reappears.

Source files
------------

// File: rtl/fifo_asym_window.sv
// Asymmetric FIFO: one word in per cycle, a window of RD_WORDS oldest words out,
// with a variable pop amount for sliding-window reuse and a drain mode for partial tails.
module fifo_asym_window #(
  parameter int WIDTH                = 16,
  parameter int DEPTH                = 128,
  parameter int RD_WORDS             = 3,
  parameter int USE_AS_EXTERNAL_FIFO = 1
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic [WIDTH-1:0]                  din,
  input  logic                              input_valid,
  output logic                              input_ready,
  output logic [RD_WORDS*WIDTH-1:0]         qout,
  output logic [$clog2(RD_WORDS+1)-1:0]     valid_words,
  output logic                              output_valid,
  input  logic                              output_ready,
  input  logic [$clog2(RD_WORDS+1)-1:0]     pop_count,
  input  logic                              drain,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int VW = $clog2(RD_WORDS + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    occ;
  logic             has_window;
  logic             push;
  logic             pop;
  logic [VW-1:0]    popped;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ   = wr_ptr - rd_ptr;
  assign count = occ;

  assign valid_words = (occ >= PW'(RD_WORDS)) ? VW'(RD_WORDS) : VW'(occ);
  assign has_window  = (occ >= PW'(RD_WORDS)) || (drain && (occ != '0));

  // Both handshake outputs are held low while reset is asserted.
  assign input_ready  = arst_n_in && (occ < PW'(DEPTH));
  assign output_valid = arst_n_in && has_window;

  assign push   = input_valid && input_ready;
  assign pop    = output_valid && output_ready;
  assign popped = !pop ? '0 : ((pop_count > valid_words) ? valid_words : pop_count);

  for (genvar i = 0; i < RD_WORDS; i++) begin : g_lane
    logic [AW-1:0] addr;
    assign addr = rd_ptr[AW-1:0] + AW'(i);
    assign qout[i*WIDTH +: WIDTH] =
      (output_valid && (VW'(i) < valid_words)) ? mem[addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr + PW'(popped);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

`ifndef TARGET_SYNTHESIS
  // Cost accounting for architecture exploration; on-chip buffers cost 0.1x energy.
  localparam real K_COST    = (USE_AS_EXTERNAL_FIFO != 0) ? 1.0 : 0.1;
  localparam real AREA_COST = (USE_AS_EXTERNAL_FIFO != 0) ? 0.0 : real'(DEPTH * WIDTH);

  real  energy;
  real  area;
  logic area_done;

  always_ff @(posedge clk) begin
    energy <= energy
            + (pop  ? real'(valid_words) * real'(WIDTH) * K_COST : 0.0)
            + (push ? real'(WIDTH) * K_COST : 0.0);
    if (!area_done) begin
      area      <= area + AREA_COST;
      area_done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_asym_window.sv
// Randomised scoreboard bench for fifo_asym_window against a queue-based reference model.
module tb_fifo_asym_window;
  localparam int W = 16;
  localparam int D = 128;
  localparam int R = 3;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic [W-1:0]  din = '0;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [R*W-1:0] qout;
  logic [1:0]    valid_words;
  logic          output_valid;
  logic          output_ready = 1'b0;
  logic [1:0]    pop_count = '0;
  logic          drain = 1'b0;
  logic [7:0]    count;

  fifo_asym_window #(.WIDTH(W), .DEPTH(D), .RD_WORDS(R), .USE_AS_EXTERNAL_FIFO(1)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .din(din), .input_valid(input_valid),
    .input_ready(input_ready), .qout(qout), .valid_words(valid_words),
    .output_valid(output_valid), .output_ready(output_ready), .pop_count(pop_count),
    .drain(drain), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cnt;
    int       vw;
    bit       ir;
    bit       ov;
    bit       skip;
    logic [R*W-1:0] q;
  } exp_t;

  int unsigned mq[$];   // reference contents, oldest first
  exp_t        sq[$];   // expected status per cycle
  exp_t        wq[$];   // expected window per accepted pop
  int          tests = 0;
  int          failed = 0;
  bit          first = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one cycle of stimulus and record what the model expects for it.
  task automatic step(input bit rst, input bit iv, input logic [W-1:0] d,
                      input bit ordy, input logic [1:0] pc, input bit dr);
    exp_t e;
    int   n;
    int   pn;
    @(negedge clk);
    arst_n_in = !rst; input_valid = iv; din = d;
    output_ready = ordy; pop_count = pc; drain = dr;
    n      = mq.size();
    e.cnt  = n;
    e.vw   = (n < R) ? n : R;
    e.ir   = !rst && (n < D);
    e.ov   = !rst && ((n >= R) || (dr && n != 0));
    e.skip = first;
    first  = 1'b0;
    e.q    = '0;
    if (e.ov) for (int i = 0; i < e.vw; i++) e.q[i*W +: W] = W'(mq[i]);
    sq.push_back(e);
    if (rst) begin
      mq.delete();
    end else begin
      pn = 0;
      if (e.ov && ordy) begin
        pn = (int'(pc) > e.vw) ? e.vw : int'(pc);
        wq.push_back(e);
      end
      for (int i = 0; i < pn; i++) void'(mq.pop_front());
      if (iv && e.ir) mq.push_back(int'(d));
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t w;
    forever begin
      @(negedge clk);
      #1;
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("input_ready", 64'(input_ready), 64'(e.ir));
        chk("output_valid", 64'(output_valid), 64'(e.ov));
        chk("qout", 64'(qout), 64'(e.q));
        if (!e.skip) begin
          chk("count", 64'(count), 64'(e.cnt));
          chk("valid_words", 64'(valid_words), 64'(e.vw));
        end
        if (output_valid && output_ready) begin
          if (wq.size() == 0) begin
            chk("unexpected_pop", 64'(1), 64'(0));
          end else begin
            w = wq.pop_front();
            chk("pop_window", 64'(qout), 64'(w.q));
            chk("pop_valid_words", 64'(valid_words), 64'(w.vw));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned v;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // push 1,2,3 then observe the full window
    for (int i = 1; i <= 3; i++) step(0, 1, W'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0);
    // push 1..5 then stride-1 pops
    for (int i = 1; i <= 5; i++) step(0, 1, W'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0, 1);
    // partial tail with drain and clamped pop
    for (int i = 1; i <= 2; i++) step(0, 1, W'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0, 1);
    // fill past capacity, then push+pop while full
    for (int i = 0; i < D + 2; i++) step(0, 1, W'($urandom), 0, 0, 0);
    step(0, 1, 16'hbeef, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 3, 1);
    // continuous stream crossing the pointer wrap
    for (int i = 0; i < 300; i++) step(0, 1, W'($urandom), 1, 3, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 3, 1);
    // build to 50 words, reset mid-stream, confirm nothing stale returns
    for (int i = 0; i < 50; i++) step(0, 1, W'($urandom), 0, 0, 0);
    step(1, 1, 16'h1234, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 4; i++) step(0, 1, W'(16'h7000 + i), 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      v = $urandom;
      step(($urandom_range(0, 299) == 0), (v[1:0] != 2'b00), W'($urandom),
           v[2], 2'(v[4:3]), (v[7:5] == 3'b000));
    end
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("status_queue_drained", 64'(sq.size()), 64'(0));
    chk("window_queue_drained", 64'(wq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
